// File: rtl/eth_tx_arb.sv
// Frame-level round-robin arbiter merging two Avalon-ST sources into the MAC TX FIFO stream.
// Latency: a beat accepted in cycle N is presented on o_tx_* in cycle N+1; one idle cycle per frame.
// Backpressure: single output register; source ready follows ~o_tx_vld | i_tx_rdy while granted.
module eth_tx_arb #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      i_a_data,
    input  logic [1:0]       i_a_mod,
    input  logic             i_a_sop,
    input  logic             i_a_eop,
    input  logic             i_a_vld,
    output logic             o_a_rdy,
    input  logic [31:0]      i_b_data,
    input  logic [1:0]       i_b_mod,
    input  logic             i_b_sop,
    input  logic             i_b_eop,
    input  logic             i_b_vld,
    output logic             o_b_rdy,
    output logic [31:0]      o_tx_data,
    output logic [1:0]       o_tx_mod,
    output logic             o_tx_sop,
    output logic             o_tx_eop,
    output logic             o_tx_vld,
    input  logic             i_tx_rdy,
    output logic [CNT_W-1:0] o_frm_cnt_a,
    output logic [CNT_W-1:0] o_frm_cnt_b,
    output logic [CNT_W-1:0] o_drop_cnt
);

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t      state, state_nxt;
    logic        last_b;
    logic        out_free;
    logic        cand_a, cand_b, pick_a, pick_b;
    logic        drop_a, drop_b;
    logic        acc_a, acc_b, load;
    logic [31:0] sel_data;
    logic [1:0]  sel_mod;
    logic        sel_sop, sel_eop;

    assign out_free = ~o_tx_vld | i_tx_rdy;
    assign cand_a   = i_a_vld & i_a_sop;
    assign cand_b   = i_b_vld & i_b_sop;
    // On a tie the source that did not win last time takes the grant.
    assign pick_a   = (state == IDLE) & cand_a & (~cand_b | last_b);
    assign pick_b   = (state == IDLE) & cand_b & ~pick_a;
    assign drop_a   = (state == IDLE) & i_a_vld & ~i_a_sop;
    assign drop_b   = (state == IDLE) & i_b_vld & ~i_b_sop;
    assign acc_a    = (state == GNT_A) & i_a_vld & o_a_rdy;
    assign acc_b    = (state == GNT_B) & i_b_vld & o_b_rdy;
    assign load     = acc_a | acc_b;

    assign sel_data = (state == GNT_B) ? i_b_data : i_a_data;
    assign sel_mod  = (state == GNT_B) ? i_b_mod  : i_a_mod;
    assign sel_sop  = (state == GNT_B) ? i_b_sop  : i_a_sop;
    assign sel_eop  = (state == GNT_B) ? i_b_eop  : i_a_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_b <= 1'b1;
        end else begin
            state <= state_nxt;
            if (pick_a)
                last_b <= 1'b0;
            else if (pick_b)
                last_b <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_a)
                    state_nxt = GNT_A;
                else if (pick_b)
                    state_nxt = GNT_B;
            end
            GNT_A:   if (acc_a & i_a_eop) state_nxt = IDLE;
            GNT_B:   if (acc_b & i_b_eop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Orphan beats (valid without sop while idle) are drained immediately.
    always_comb begin
        o_a_rdy = 1'b0;
        o_b_rdy = 1'b0;
        case (state)
            IDLE: begin
                o_a_rdy = i_a_vld & ~i_a_sop;
                o_b_rdy = i_b_vld & ~i_b_sop;
            end
            GNT_A:   o_a_rdy = out_free;
            GNT_B:   o_b_rdy = out_free;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_tx_vld  <= 1'b0;
            o_tx_data <= '0;
            o_tx_mod  <= '0;
            o_tx_sop  <= 1'b0;
            o_tx_eop  <= 1'b0;
        end else if (out_free) begin
            o_tx_vld <= load;
            if (load) begin
                o_tx_data <= sel_data;
                o_tx_mod  <= sel_eop ? sel_mod : 2'd0;
                o_tx_sop  <= sel_sop;
                o_tx_eop  <= sel_eop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_frm_cnt_a <= '0;
            o_frm_cnt_b <= '0;
            o_drop_cnt  <= '0;
        end else begin
            if (acc_a & i_a_eop)
                o_frm_cnt_a <= o_frm_cnt_a + 1'b1;
            if (acc_b & i_b_eop)
                o_frm_cnt_b <= o_frm_cnt_b + 1'b1;
            o_drop_cnt <= o_drop_cnt + CNT_W'(drop_a) + CNT_W'(drop_b);
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb with an expected-beat queue checked at the output.
module tb_eth_tx_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_mod, b_mod;
    logic        a_sop, a_eop, a_vld, a_rdy;
    logic        b_sop, b_eop, b_vld, b_rdy;
    logic [31:0] tx_data;
    logic [1:0]  tx_mod;
    logic        tx_sop, tx_eop, tx_vld, tx_rdy;
    logic [15:0] cnt_a, cnt_b, cnt_drop;

    logic        a_rdy2, b_rdy2;
    logic [31:0] tx_data2;
    logic [1:0]  tx_mod2;
    logic        tx_sop2, tx_eop2, tx_vld2;
    logic [1:0]  cnt_a2, cnt_b2, cnt_drop2;

    always #5 clk = ~clk;

    eth_tx_arb #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_a_data(a_data), .i_a_mod(a_mod), .i_a_sop(a_sop), .i_a_eop(a_eop),
        .i_a_vld(a_vld), .o_a_rdy(a_rdy),
        .i_b_data(b_data), .i_b_mod(b_mod), .i_b_sop(b_sop), .i_b_eop(b_eop),
        .i_b_vld(b_vld), .o_b_rdy(b_rdy),
        .o_tx_data(tx_data), .o_tx_mod(tx_mod), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
        .o_tx_vld(tx_vld), .i_tx_rdy(tx_rdy),
        .o_frm_cnt_a(cnt_a), .o_frm_cnt_b(cnt_b), .o_drop_cnt(cnt_drop)
    );

    // Narrow-counter copy sharing the same stimulus, used for wrap checks.
    eth_tx_arb #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .i_a_data(a_data), .i_a_mod(a_mod), .i_a_sop(a_sop), .i_a_eop(a_eop),
        .i_a_vld(a_vld), .o_a_rdy(a_rdy2),
        .i_b_data(b_data), .i_b_mod(b_mod), .i_b_sop(b_sop), .i_b_eop(b_eop),
        .i_b_vld(b_vld), .o_b_rdy(b_rdy2),
        .o_tx_data(tx_data2), .o_tx_mod(tx_mod2), .o_tx_sop(tx_sop2), .o_tx_eop(tx_eop2),
        .o_tx_vld(tx_vld2), .i_tx_rdy(tx_rdy),
        .o_frm_cnt_a(cnt_a2), .o_frm_cnt_b(cnt_b2), .o_drop_cnt(cnt_drop2)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  m;
        logic        s;
        logic        e;
    } beat_t;

    beat_t       sb[$];
    int          n_assert = 0;
    int          n_fail = 0;
    bit          bp_chk = 1'b0;
    bit          bp_hold = 1'b0;
    beat_t       hold_beat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [31:0] base, input int n, input logic [1:0] m);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + i;
            b.m = (i == n - 1) ? m : 2'd0;
            b.s = (i == 0);
            b.e = (i == n - 1);
            sb.push_back(b);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input bit sel, input logic [31:0] d, input logic [1:0] m,
                        input logic s, input logic e);
        bit done = 1'b0;
        if (!sel) begin
            a_data = d; a_mod = m; a_sop = s; a_eop = e; a_vld = 1'b1;
        end else begin
            b_data = d; b_mod = m; b_sop = s; b_eop = e; b_vld = 1'b1;
        end
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = sel ? (b_vld && b_rdy) : (a_vld && a_rdy);
        end
        chk("beat_accepted", done, 1);
        @(posedge clk);
        #1;
        if (!sel) a_vld = 1'b0;
        else      b_vld = 1'b0;
    endtask

    // Non-eop beats carry a nonzero mod to confirm the output forces it to 0.
    task automatic frame(input bit sel, input logic [31:0] base, input int n, input logic [1:0] m);
        for (int i = 0; i < n; i++)
            beat(sel, base + i, m, i == 0, i == n - 1);
    endtask

    task automatic drain;
        for (int c = 0; c < 200 && (sb.size() != 0 || tx_vld); c++)
            cycles(1);
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        beat_t got, exp;
        if (!rst_n) begin
            bp_hold = 1'b0;
        end else begin
            got = '{tx_data, tx_mod, tx_sop, tx_eop};
            if (bp_hold) begin
                chk("hold_vld", tx_vld, 1);
                chk("hold_beat", got, hold_beat);
            end
            if (bp_chk && tx_vld && !tx_rdy)
                chk("a_rdy_when_full", a_rdy, 0);
            if (tx_vld && tx_rdy) begin
                chk("unexpected_beat", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp = sb.pop_front();
                    chk("out_beat", got, exp);
                end
            end
            bp_hold   = tx_vld && !tx_rdy;
            hold_beat = got;
        end
    end

    initial begin
        int z;
        bit seen;
        a_data = '0; a_mod = '0; a_sop = 0; a_eop = 0; a_vld = 0;
        b_data = '0; b_mod = '0; b_sop = 0; b_eop = 0; b_vld = 0;
        tx_rdy = 1'b1;
        cycles(3);
        chk("rst_tx_vld", tx_vld, 0);
        chk("rst_tx_data", {tx_data, tx_mod, tx_sop, tx_eop}, 0);
        chk("rst_rdy", {a_rdy, b_rdy}, 0);
        chk("rst_cnts", {cnt_a, cnt_b, cnt_drop}, 0);
        rst_n = 1'b1;
        cycles(1);

        // Single 4-beat frame from A, first output two cycles after valid rises.
        push_frame(32'hA000_0000, 4, 2'd2);
        z = 0;
        seen = 1'b0;
        fork
            frame(0, 32'hA000_0000, 4, 2'd2);
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (tx_vld) seen = 1'b1;
                else z++;
            end
        join
        chk("first_beat_latency", z, 2);
        drain();
        chk("single_cnt_a", cnt_a, 1);

        // Contention from reset: A first, then strict alternation.
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        push_frame(32'h1A00_0000, 3, 2'd1);
        push_frame(32'h1B00_0000, 3, 2'd3);
        push_frame(32'h2A00_0000, 3, 2'd0);
        push_frame(32'h2B00_0000, 3, 2'd2);
        fork
            frame(0, 32'h1A00_0000, 3, 2'd1);
            frame(1, 32'h1B00_0000, 3, 2'd3);
        join
        fork
            frame(0, 32'h2A00_0000, 3, 2'd0);
            frame(1, 32'h2B00_0000, 3, 2'd2);
        join
        drain();
        chk("contend_cnt_a", cnt_a, 2);
        chk("contend_cnt_b", cnt_b, 2);

        // Backpressure pattern 1,0,0 repeating during a 5-beat frame.
        bp_chk = 1'b1;
        push_frame(32'hC000_0000, 5, 2'd1);
        fork
            frame(0, 32'hC000_0000, 5, 2'd1);
            for (int c = 0; c < 40; c++) begin
                tx_rdy = (c % 3 == 0);
                cycles(1);
            end
        join
        tx_rdy = 1'b1;
        drain();
        bp_chk = 1'b0;
        chk("bp_cnt_a", cnt_a, 3);

        // Orphans on B, then a single-beat frame.
        beat(1, 32'hDEAD_0001, 2'd0, 0, 0);
        beat(1, 32'hDEAD_0002, 2'd0, 0, 0);
        chk("orphan_drop_cnt", cnt_drop, 2);
        push_frame(32'hB100_0000, 1, 2'd3);
        frame(1, 32'hB100_0000, 1, 2'd3);
        drain();
        chk("orphan_cnt_b", cnt_b, 3);
        fork
            beat(0, 32'hDEAD_0003, 2'd0, 0, 1);
            beat(1, 32'hDEAD_0004, 2'd0, 0, 0);
        join
        chk("dual_orphan_drop_cnt", cnt_drop, 4);
        chk("dual_orphan_no_frame", {cnt_a, cnt_b}, {16'd3, 16'd3});

        // Reset in the middle of an A frame.
        push_frame(32'hE000_0000, 6, 2'd0);
        beat(0, 32'hE000_0000, 2'd0, 1, 0);
        beat(0, 32'hE000_0001, 2'd0, 0, 0);
        beat(0, 32'hE000_0002, 2'd0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx_vld", tx_vld, 0);
        chk("midrst_cnts", {cnt_a, cnt_b, cnt_drop}, 0);
        chk("midrst_cnts2", {cnt_a2, cnt_b2, cnt_drop2}, 0);
        sb.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        push_frame(32'hB200_0000, 2, 2'd1);
        frame(1, 32'hB200_0000, 2, 2'd1);
        drain();
        chk("post_rst_cnt_b", cnt_b, 1);
        chk("post_rst_cnt_a", cnt_a, 0);

        // Five A frames wrap the 2-bit counter to 1.
        for (int f = 0; f < 5; f++) begin
            push_frame(32'hF000_0000 + (f << 8), 2, 2'(f));
            frame(0, 32'hF000_0000 + (f << 8), 2, 2'(f));
        end
        drain();
        chk("wrap_cnt_a16", cnt_a, 5);
        chk("wrap_cnt_a2", cnt_a2, 1);
        chk("wrap_cnt_b2", cnt_b2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Frame-level arbiter that sits directly upstream of a MAC transmit FIFO interface (ff_tx_*: 32-bit data, 2-bit mod, sop/eop, wren/rdy).
- Merges two Avalon-ST style sources into one stream:
  - Source A: the port-to-port pump FIFO output.
  - Source B: host/eth_top transmit traffic.
- Whole frames are granted round-robin and never interleaved. The output is registered. Orphan beats are dropped and counted.

Parameters:
- CNT_W, 16, width of frame and drop counters (wrap on overflow).

Ports:
- clk  in  1  system clock; all logic is on this clock.
- rst_n  in  1  asynchronous active-low reset.
- i_a_data  in  32  source A data word.
- i_a_mod  in  2  source A empty-byte count, meaningful on eop beat (0 = all 4 bytes valid).
- i_a_sop  in  1  source A start of frame.
- i_a_eop  in  1  source A end of frame.
- i_a_vld  in  1  source A beat valid.
- o_a_rdy  out  1  source A beat accepted when i_a_vld & o_a_rdy.
- i_b_data, i_b_mod, i_b_sop, i_b_eop, i_b_vld, o_b_rdy: same as source A, for source B.
- o_tx_data  out  32  to MAC ff_tx_data.
- o_tx_mod  out  2  to MAC ff_tx_mod.
- o_tx_sop  out  1  to MAC ff_tx_sop.
- o_tx_eop  out  1  to MAC ff_tx_eop.
- o_tx_vld  out  1  to MAC ff_tx_wren.
- i_tx_rdy  in  1  from MAC ff_tx_rdy; beat transfers when o_tx_vld & i_tx_rdy.
- o_frm_cnt_a  out  CNT_W  frames (eop beats) forwarded from A.
- o_frm_cnt_b  out  CNT_W  frames forwarded from B.
- o_drop_cnt  out  CNT_W  orphan beats discarded (both sources).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; last_grant=B, so A wins the first tie.
  - Output register empty: o_tx_vld=0; o_tx_data/mod/sop/eop=0.
  - All counters 0; o_a_rdy=o_b_rdy=0.
  - Reset mid-frame truncates the frame silently, with no eop generated.
- Output register:
  - Single stage. Loads when out_free = ~o_tx_vld | i_tx_rdy.
  - o_tx_vld clears when a beat transfers and no new beat loads.
  - Latency: a source beat accepted in cycle N appears on o_tx_* in cycle N+1.
  - Zero-bubble throughput when i_tx_rdy=1 continuously.
- States: IDLE, GNT_A, GNT_B.
- IDLE:
  - o_a_rdy=o_b_rdy=0, except orphan draining (see below).
  - Candidate X means i_X_vld & i_X_sop.
  - If both are candidates, grant the source != last_grant. Otherwise grant the sole candidate.
  - Transition to GNT_X next cycle; set last_grant=X.
  - No beat is transferred in the arbitration cycle, so there is one bubble per frame.
- Orphan draining in IDLE:
  - Applies to a source with i_X_vld=1 & i_X_sop=0 that is not granted.
  - o_X_rdy=1; the beat is discarded and o_drop_cnt increments.
  - Both sources orphan in the same cycle: o_drop_cnt += 2.
- GNT_X:
  - o_X_rdy = out_free; the other source's rdy=0.
  - An accepted beat loads the output register.
  - o_tx_mod = i_X_mod when i_X_eop=1, else forced 0.
- eop beat accepted in GNT_X: o_frm_cnt_X increments; next state IDLE.
- Single-beat frame (sop & eop on the same beat): forwarded; counts one frame; returns to IDLE.
- sop arriving mid-frame (missing eop): passed through unchanged, with no repair and no counting. The grant is held until the next eop.
- Backpressure: while i_tx_rdy=0 with o_tx_vld=1, the output holds stable and o_X_rdy=0. No beat is lost or duplicated.
- Counters wrap modulo 2^CNT_W.

Test Plan:
- Single frame: A sends 4 beats (sop on beat 0, eop on beat 3, mod=2), i_tx_rdy=1 → o_tx_* reproduces the 4 beats in order starting 2 cycles after i_a_vld first asserts, mod=2 on eop only; o_frm_cnt_a=1.
- Contention: A and B both present a 3-beat frame from reset → A's frame emitted first, then B's (one IDLE bubble between); repeat both → A again (strict alternation); no interleaving; counts A=2, B=2.
- Backpressure: i_tx_rdy toggles 1,0,0,1,... during a 5-beat frame → every word appears exactly once, held stable while rdy=0; o_a_rdy low whenever the output register is full and i_tx_rdy=0.
- Orphans: B drives 2 valid beats with no sop while idle, then a 1-beat sop+eop frame → o_drop_cnt=2; single frame forwarded with sop=eop=1; o_frm_cnt_b=1.
- Reset mid-frame: rst_n pulsed low after beat 2 of an A frame → o_tx_vld=0 immediately (async); counters 0; next B sop frame is granted normally.
- Wrap: CNT_W=2, send 5 A frames → o_frm_cnt_a=1.
